// File: rtl/sobel_pkg.sv
// Shared widths, window tap indices and small helpers for the Sobel edge pipeline.
package sobel_pkg;

  localparam int unsigned PIX_W    = 8;
  localparam int unsigned WIN_PIX  = 9;
  localparam int unsigned WIN_W    = PIX_W * WIN_PIX;
  localparam int unsigned PSUM_W   = 10;
  localparam int unsigned GRAD_W   = 11;
  localparam int unsigned MAG_SQ_W = 21;

  // Window pixel k = 3*row + col; row 0 is the oldest line, col 0 the leftmost column.
  localparam int unsigned P0 = 0;
  localparam int unsigned P1 = 1;
  localparam int unsigned P2 = 2;
  localparam int unsigned P3 = 3;
  localparam int unsigned P4 = 4;
  localparam int unsigned P5 = 5;
  localparam int unsigned P6 = 6;
  localparam int unsigned P7 = 7;
  localparam int unsigned P8 = 8;

  typedef logic [PIX_W-1:0]         pix_t;
  typedef logic [PSUM_W-1:0]        psum_t;
  typedef logic signed [GRAD_W-1:0] grad_t;
  typedef logic [PSUM_W-1:0]        mag_t;

  function automatic pix_t win_pix(input logic [WIN_W-1:0] win, input int unsigned k);
    return win[k*PIX_W +: PIX_W];
  endfunction

  // a + 2b + c; the centre tap carries double weight.
  function automatic psum_t tap_sum(input pix_t a, input pix_t b, input pix_t c);
    return psum_t'(a) + (psum_t'(b) << 1) + psum_t'(c);
  endfunction

endpackage

// File: rtl/sobel_conv_if.sv
// Window-in / edge-pixel-out stream bundle for sobel_conv (no backpressure).
interface sobel_conv_if;
  import sobel_pkg::*;

  logic [WIN_W-1:0] i_pixel_data;
  logic             i_pixel_data_valid;
  logic [PIX_W-1:0] o_convolved_data;
  logic             o_convolved_data_valid;
  logic             o_line_last;

  modport master (
    output i_pixel_data,
    output i_pixel_data_valid,
    input  o_convolved_data,
    input  o_convolved_data_valid,
    input  o_line_last
  );

  modport slave (
    input  i_pixel_data,
    input  i_pixel_data_valid,
    output o_convolved_data,
    output o_convolved_data_valid,
    output o_line_last
  );

endinterface

// File: rtl/sobel_grad.sv
// Stages 1-2 of one Sobel axis: weighted tap sums, then registered absolute gradient.
module sobel_grad
  import sobel_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load_s1,
  input  logic load_s2,
  input  pix_t pos_a,
  input  pix_t pos_b,
  input  pix_t pos_c,
  input  pix_t neg_a,
  input  pix_t neg_b,
  input  pix_t neg_c,
  output mag_t mag
);

  psum_t pos_sum_q, neg_sum_q;
  mag_t  mag_q;
  grad_t diff;
  mag_t  abs_g;

  always_comb begin
    diff  = grad_t'({1'b0, pos_sum_q}) - grad_t'({1'b0, neg_sum_q});
    // |diff| <= 1020, so the negated value always fits the unsigned magnitude.
    abs_g = diff[GRAD_W-1] ? mag_t'(-diff) : mag_t'(diff);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pos_sum_q <= '0;
      neg_sum_q <= '0;
      mag_q     <= '0;
    end else begin
      if (load_s1) begin
        pos_sum_q <= tap_sum(pos_a, pos_b, pos_c);
        neg_sum_q <= tap_sum(neg_a, neg_b, neg_c);
      end
      if (load_s2) begin
        mag_q <= abs_g;
      end
    end
  end

  assign mag = mag_q;

endmodule

// File: rtl/sobel_conv.sv
// 3-stage pipelined 3x3 Sobel operator with line-end marker.
// Define SOBEL_THRESH_EN for binary output from |Gx|^2+|Gy|^2 > THRESHOLD.
module sobel_conv
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_WIDTH = 512,
  parameter int unsigned THRESHOLD = 4000
) (
  input logic         i_clk,
  input logic         i_rst,
  sobel_conv_if.slave bus
);

  localparam int unsigned CntW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(IMG_WIDTH - 1);

  if (THRESHOLD >= (64'd1 << MAG_SQ_W)) begin : g_thresh_range
    $error("THRESHOLD does not fit the squared-magnitude width");
  end

  logic [2:0]      vld_q;
  logic [WIN_W-1:0] win;
  mag_t            gx_mag, gy_mag;
  pix_t            pix_next;
  pix_t            data_q;
  logic            last_q;
  logic [CntW-1:0] cnt_q;

  assign win = bus.i_pixel_data;

  sobel_grad u_gx (
    .clk     (i_clk),
    .rst     (i_rst),
    .load_s1 (bus.i_pixel_data_valid),
    .load_s2 (vld_q[0]),
    .pos_a   (win_pix(win, P2)),
    .pos_b   (win_pix(win, P5)),
    .pos_c   (win_pix(win, P8)),
    .neg_a   (win_pix(win, P0)),
    .neg_b   (win_pix(win, P3)),
    .neg_c   (win_pix(win, P6)),
    .mag     (gx_mag)
  );

  sobel_grad u_gy (
    .clk     (i_clk),
    .rst     (i_rst),
    .load_s1 (bus.i_pixel_data_valid),
    .load_s2 (vld_q[0]),
    .pos_a   (win_pix(win, P6)),
    .pos_b   (win_pix(win, P7)),
    .pos_c   (win_pix(win, P8)),
    .neg_a   (win_pix(win, P0)),
    .neg_b   (win_pix(win, P1)),
    .neg_c   (win_pix(win, P2)),
    .mag     (gy_mag)
  );

`ifdef SOBEL_THRESH_EN
  logic [MAG_SQ_W-1:0] mag_sq;

  always_comb begin
    mag_sq   = MAG_SQ_W'(gx_mag) * MAG_SQ_W'(gx_mag) + MAG_SQ_W'(gy_mag) * MAG_SQ_W'(gy_mag);
    pix_next = (mag_sq > MAG_SQ_W'(THRESHOLD)) ? 8'hFF : 8'h00;
  end
`else
  logic [GRAD_W-1:0] mag_sum;

  always_comb begin
    mag_sum  = GRAD_W'(gx_mag) + GRAD_W'(gy_mag);
    pix_next = (mag_sum > GRAD_W'(255)) ? 8'hFF : mag_sum[PIX_W-1:0];
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_q  <= '0;
      data_q <= '0;
      last_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      vld_q  <= {vld_q[1:0], bus.i_pixel_data_valid};
      last_q <= vld_q[1] && (cnt_q == CntMax);
      if (vld_q[1]) begin
        data_q <= pix_next;
        cnt_q  <= (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
      end
    end
  end

  assign bus.o_convolved_data       = data_q;
  assign bus.o_convolved_data_valid = vld_q[2];
  assign bus.o_line_last            = last_q;

endmodule

// File: tb/tb_sobel_conv.sv
// Directed self-checking bench for sobel_conv: latency, values, line markers, reset flush.
module tb_sobel_conv;

  localparam int unsigned ImgW = 512;
`ifdef SOBEL_THRESH_EN
  localparam bit ThreshEn = 1'b1;
`else
  localparam bit ThreshEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sobel_conv_if bus ();

  sobel_conv #(
    .IMG_WIDTH (ImgW),
    .THRESHOLD (4000)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int out_cnt = 0;
  int last_cnt = 0;
  int line_idx = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] mkwin(input logic [7:0] p0, p1, p2, p3, p4, p5, p6, p7, p8);
    return {p8, p7, p6, p5, p4, p3, p2, p1, p0};
  endfunction

  // Reference Sobel from the textbook equations on plain integers.
  function automatic logic [7:0] model(input logic [71:0] w);
    int p[9];
    int gx, gy, ax, ay;
    for (int k = 0; k < 9; k++) p[k] = int'(w[8*k +: 8]);
    gx = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
    gy = (p[6] + 2*p[7] + p[8]) - (p[0] + 2*p[1] + p[2]);
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    if (ThreshEn) return (ax*ax + ay*ay > 4000) ? 8'hFF : 8'h00;
    return (ax + ay > 255) ? 8'hFF : 8'(ax + ay);
  endfunction

  // Output monitor: order, data and line-last against the model queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_convolved_data_valid) begin
        check("out_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("out_data", bus.o_convolved_data, exp_q.pop_front());
        check("line_last", bus.o_line_last, 32'(line_idx == ImgW - 1));
        if (bus.o_line_last) last_cnt++;
        out_cnt++;
        line_idx = (line_idx == ImgW - 1) ? 0 : line_idx + 1;
      end else begin
        check("last_idle", bus.o_line_last, 32'd0);
      end
    end
  end

  task automatic drive(input logic [71:0] w, input logic v);
    @(posedge clk);
    #1;
    bus.i_pixel_data       = w;
    bus.i_pixel_data_valid = v;
    if (v && !rst) exp_q.push_back(model(w));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.i_pixel_data_valid = 1'b0;
    exp_q.delete();
    line_idx = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One isolated window: checks exact 3-cycle latency, single valid pulse and hold.
  task automatic single(input string tag, input logic [71:0] w, input logic [7:0] e_def,
                        input logic [7:0] e_thr);
    logic [7:0] e;
    e = ThreshEn ? e_thr : e_def;
    drive(w, 1'b1);
    drive(72'd0, 1'b0);
    @(negedge clk);
    check({tag, "_v1"}, bus.o_convolved_data_valid, 32'd0);
    @(negedge clk);
    check({tag, "_v2"}, bus.o_convolved_data_valid, 32'd0);
    @(negedge clk);
    check({tag, "_v3"}, bus.o_convolved_data_valid, 32'd1);
    check({tag, "_data"}, bus.o_convolved_data, e);
    @(negedge clk);
    check({tag, "_v4"}, bus.o_convolved_data_valid, 32'd0);
    check({tag, "_hold"}, bus.o_convolved_data, e);
  endtask

  initial begin
    int base_out, base_last;
    bus.i_pixel_data       = '0;
    bus.i_pixel_data_valid = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_data", bus.o_convolved_data, 32'd0);
    check("rst_valid", bus.o_convolved_data_valid, 32'd0);
    check("rst_last", bus.o_line_last, 32'd0);

    single("flat80", mkwin(8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80),
           8'h00, 8'h00);
    single("rcol10", mkwin(0, 0, 8'h10, 0, 0, 8'h10, 0, 0, 8'h10), 8'h40, 8'hFF);
    single("rcol0f", mkwin(0, 0, 8'h0F, 0, 0, 8'h0F, 0, 0, 8'h0F), 8'h3C, 8'h00);
    single("p8ff", mkwin(0, 0, 0, 0, 0, 0, 0, 0, 8'hFF), 8'hFF, 8'hFF);
    single("lcol20", mkwin(8'h20, 0, 0, 8'h20, 0, 0, 8'h20, 0, 0), 8'h80, 8'hFF);
    single("trow30", mkwin(8'h30, 8'h30, 8'h30, 0, 0, 0, 0, 0, 0), 8'hC0, 8'hFF);
    single("m254", mkwin(0, 0, 0, 0, 0, 8'h7F, 0, 0, 0), 8'hFE, 8'hFF);
    single("m256", mkwin(0, 0, 0, 0, 0, 8'h7F, 0, 0, 8'h01), 8'hFF, 8'hFF);
    // Gx=60, Gy=20: squared magnitude exactly 4000 is not above threshold.
    single("sq4000", mkwin(0, 0, 0, 0, 0, 8'h1E, 0, 8'h0A, 0), 8'h50, 8'h00);

    // 1024 random windows with sporadic bubbles.
    do_reset();
    base_out  = out_cnt;
    base_last = last_cnt;
    for (int i = 0; i < 1024; i++) begin
      drive({$urandom, $urandom, $urandom}, 1'b1);
      if ($urandom_range(0, 3) == 0) drive(72'd0, 1'b0);
    end
    drive(72'd0, 1'b0);
    repeat (6) @(negedge clk);
    check("stream_count", out_cnt - base_out, 32'd1024);
    check("stream_lasts", last_cnt - base_last, 32'd2);
    check("stream_drained", exp_q.size(), 32'd0);

    // Two windows in flight, then a 1-cycle reset with valid held high.
    drive(mkwin(0, 0, 8'hFF, 0, 0, 8'hFF, 0, 0, 8'hFF), 1'b1);
    drive(mkwin(0, 0, 8'h10, 0, 0, 8'h10, 0, 0, 8'h10), 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    line_idx = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.i_pixel_data_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("flush_valid", bus.o_convolved_data_valid, 32'd0);
      check("flush_data", bus.o_convolved_data, 32'd0);
    end

    // 600 back-to-back windows: no gaps from the third cycle on, one line end.
    base_out  = out_cnt;
    base_last = last_cnt;
    for (int i = 0; i < 600; i++) begin
      drive({$urandom, $urandom, $urandom}, 1'b1);
      @(negedge clk);
      check("cont_valid", bus.o_convolved_data_valid, 32'(i >= 3));
    end
    drive(72'd0, 1'b0);
    repeat (6) @(negedge clk);
    check("cont_count", out_cnt - base_out, 32'd600);
    check("cont_lasts", last_cnt - base_last, 32'd1);
    check("cont_line_idx", line_idx, 32'd88);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
